// File: rtl/frame_sequencer.sv
// Frame sequencer: drives a 10-bit SPI command protocol to a pixel chip,
// runs CAL -> READOUT -> IDLE sequences or single individual-pixel commands,
// and counts end-of-frame edges during readout.
// Optional echo check: define FRAME_SEQUENCER_ECHO_CHECK_EN to repeat every
// CAL/READOUT/IDLE word and flag a mismatch of the echoed mode bits on err.
module frame_sequencer #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic             abort,
  input  logic             indiv_en,
  input  logic [6:0]       indiv_col,
  input  logic             indiv_adc,
  input  logic [CNT_W-1:0] cal_cycles,
  input  logic [CNT_W-1:0] n_frames,
  input  logic             spi_CtoF,
  input  logic             EoF,
  output logic             spi_FtoC,
  output logic             spi_ss,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err
);

  localparam int unsigned WordLen  = 10;
  localparam int unsigned SlotLen  = WordLen + GAP_CYCLES;
  localparam logic [4:0]  LastSlot = 5'(SlotLen - 1);

`ifdef FRAME_SEQUENCER_ECHO_CHECK_EN
  localparam bit EchoEn = 1'b1;
`else
  localparam bit EchoEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle, StCalTx, StCalWait, StRoTx, StRoRun, StStopTx, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       slot_q, slot_d;       // position in transaction + gap slot
  logic             rep_q, rep_d;         // current transaction is the echo repeat
  logic             abort_pend_q, abort_pend_d;
  logic             indiv_q, indiv_d;
  logic             indiv_adc_q, indiv_adc_d;
  logic [6:0]       indiv_col_q, indiv_col_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic             eof_q, eof_prev_q, eof_rise;
  logic             spi_ss_q, spi_ss_d;
  logic             spi_ftoc_q, spi_ftoc_d;
  logic             abort_now;
  logic [9:0]       tx_word_d;

  function automatic logic is_tx(state_e st);
    return st inside {StCalTx, StRoTx, StStopTx};
  endfunction

  // Individual-pixel words are carried by StStopTx, which always ends in StDone.
  function automatic logic [9:0] word_of(state_e st, logic ind, logic adc, logic [6:0] col);
    logic [9:0] w;
    case (st)
      StCalTx:  w = 10'h100;
      StRoTx:   w = 10'h200;
      StStopTx: w = ind ? {2'b11, adc, col} : 10'h000;
      default:  w = 10'h000;
    endcase
    return w;
  endfunction

  assign eof_rise  = eof_q & ~eof_prev_q;
  // A pending or fresh abort only redirects CAL/READOUT transmissions.
  assign abort_now = (state_q != StStopTx) && (abort_pend_q || abort);

  // Next-state, slot counting and frame counting.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    rep_d        = rep_q;
    abort_pend_d = abort_pend_q;
    indiv_d      = indiv_q;
    indiv_adc_d  = indiv_adc_q;
    indiv_col_d  = indiv_col_q;
    wait_d       = wait_q;
    frame_d      = frame_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = indiv_en ? StStopTx : StCalTx;
          slot_d       = '0;
          rep_d        = 1'b0;
          abort_pend_d = 1'b0;
          indiv_d      = indiv_en;
          indiv_adc_d  = indiv_adc;
          indiv_col_d  = indiv_col;
          frame_d      = '0;
        end
      end
      StCalTx, StRoTx, StStopTx: begin
        if (abort && state_q != StStopTx) abort_pend_d = 1'b1;
        slot_d = slot_q + 5'd1;
        if (slot_q == LastSlot) begin
          slot_d = '0;
          if (EchoEn && !rep_q && !indiv_q && !abort_now) begin
            rep_d = 1'b1;
          end else begin
            rep_d = 1'b0;
            if (abort_now) begin
              state_d      = StStopTx;
              abort_pend_d = 1'b0;
            end else begin
              case (state_q)
                StCalTx: begin
                  if (cal_cycles != '0) begin
                    state_d = StCalWait;
                    wait_d  = '0;
                  end else begin
                    state_d = (n_frames != '0) ? StRoTx : StStopTx;
                  end
                end
                StRoTx:  state_d = StRoRun;
                default: state_d = StDone;
              endcase
            end
          end
        end
      end
      StCalWait: begin
        if (abort) begin
          state_d = StStopTx;
          slot_d  = '0;
          rep_d   = 1'b0;
        end else if (wait_q == cal_cycles - CNT_W'(1)) begin
          state_d = (n_frames != '0) ? StRoTx : StStopTx;
          slot_d  = '0;
          rep_d   = 1'b0;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      StRoRun: begin
        if (eof_rise && frame_q != '1) frame_d = frame_q + CNT_W'(1);
        if (abort || frame_q >= n_frames) begin
          state_d = StStopTx;
          slot_d  = '0;
          rep_d   = 1'b0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Serial outputs are registered from the next state so they line up with it.
  always_comb begin
    tx_word_d  = word_of(state_d, indiv_d, indiv_adc_d, indiv_col_d);
    spi_ss_d   = 1'b1;
    spi_ftoc_d = 1'b0;
    if (is_tx(state_d) && slot_d < 5'(WordLen)) begin
      spi_ss_d   = 1'b0;
      spi_ftoc_d = tx_word_d[4'd9 - slot_d[3:0]];
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= StIdle;
      slot_q       <= '0;
      rep_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      indiv_q      <= 1'b0;
      indiv_adc_q  <= 1'b0;
      indiv_col_q  <= '0;
      wait_q       <= '0;
      frame_q      <= '0;
      eof_q        <= 1'b0;
      eof_prev_q   <= 1'b0;
      spi_ss_q     <= 1'b1;
      spi_ftoc_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      rep_q        <= rep_d;
      abort_pend_q <= abort_pend_d;
      indiv_q      <= indiv_d;
      indiv_adc_q  <= indiv_adc_d;
      indiv_col_q  <= indiv_col_d;
      wait_q       <= wait_d;
      frame_q      <= frame_d;
      eof_q        <= EoF;
      eof_prev_q   <= eof_q;
      spi_ss_q     <= spi_ss_d;
      spi_ftoc_q   <= spi_ftoc_d;
    end
  end

`ifdef FRAME_SEQUENCER_ECHO_CHECK_EN
  logic [9:0] rx_q, rx_d;
  logic       err_q, err_d;
  logic [9:0] cur_word;

  assign cur_word = word_of(state_q, indiv_q, indiv_adc_q, indiv_col_q);

  // Shift the response on the edges ending T1..T10; judge the repeat on the last one.
  always_comb begin
    rx_d  = rx_q;
    err_d = err_q;
    if (is_tx(state_q) && slot_q >= 5'd1 && slot_q <= 5'd10) begin
      rx_d = {rx_q[8:0], spi_CtoF};
      if (rep_q && slot_q == 5'd10 && rx_d[9:8] != cur_word[9:8]) err_d = 1'b1;
    end
  end

  // Response shift register and sticky error flag.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rx_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rx_q  <= rx_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_ctof;
  assign unused_ctof = spi_CtoF;
  assign err         = 1'b0;
`endif

  assign spi_ss    = spi_ss_q;
  assign spi_FtoC  = spi_ftoc_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign frame_cnt = frame_q;

endmodule
